// File: rtl/ultrasonic_pkg.sv
// Shared ultrasonic definitions: FSM encoding, distance format and default timing.
// Other ultrasonic blocks reuse these defaults.
package ultrasonic_pkg;

  localparam int DIST_W = 16;
  localparam logic [DIST_W-1:0] DIST_TIMEOUT_VAL = 16'hFFFF;

  localparam int US_N_SENSORS      = 4;
  localparam int US_TRIG_CYCLES    = 500;
  localparam int US_TICK_DIV       = 294;
  localparam int US_TIMEOUT_CYCLES = 1_500_000;
  localparam int US_GAP_CYCLES     = 500_000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_GAP
  } us_state_e;

  function automatic int us_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ultrasonic_scheduler_if.sv
// Board-side bundle for the ultrasonic scheduler: enable, echo probes, trig and tagged results.
// sensor_mask exists only when ULTRASONIC_SENSOR_MASK_EN is defined.
interface ultrasonic_scheduler_if #(
  parameter int N_SENSORS = 4
);
  import ultrasonic_pkg::*;

  localparam int IDW = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;

  logic                 enable;
  logic [N_SENSORS-1:0] probe;
  logic [N_SENSORS-1:0] trig;
  logic [DIST_W-1:0]    dist_data;
  logic [IDW-1:0]       dist_id;
  logic                 dist_valid;
  logic                 dist_timeout;
  logic                 busy;
`ifdef ULTRASONIC_SENSOR_MASK_EN
  logic [N_SENSORS-1:0] sensor_mask;

  modport master (
    output enable, probe, sensor_mask,
    input  trig, dist_data, dist_id, dist_valid, dist_timeout, busy
  );
  modport slave (
    input  enable, probe, sensor_mask,
    output trig, dist_data, dist_id, dist_valid, dist_timeout, busy
  );
`else
  modport master (
    output enable, probe,
    input  trig, dist_data, dist_id, dist_valid, dist_timeout, busy
  );
  modport slave (
    input  enable, probe,
    output trig, dist_data, dist_id, dist_valid, dist_timeout, busy
  );
`endif

endinterface

// File: rtl/ultrasonic_echo_timer.sv
// Echo width timer: TICK_DIV-cycle prescaler feeding a saturating distance counter.
module ultrasonic_echo_timer
  import ultrasonic_pkg::*;
#(
  parameter int TICK_DIV = US_TICK_DIV
) (
  input  logic              i_clk0,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_run,
  output logic [DIST_W-1:0] o_dist
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LOAD = PW'(TICK_DIV - 1);

  logic [PW-1:0]     r_presc;
  logic [DIST_W-1:0] r_dist;

  always_ff @(posedge i_clk0) begin
    if (i_rst) begin
      r_presc <= '0;
      r_dist  <= '0;
    end else if (i_clear) begin
      r_presc <= PRESC_LOAD;
      r_dist  <= '0;
    end else if (i_run) begin
      if (r_presc == '0) begin
        r_presc <= PRESC_LOAD;
        if (r_dist != {DIST_W{1'b1}}) r_dist <= r_dist + 1'b1;
      end else begin
        r_presc <= r_presc - 1'b1;
      end
    end
  end

  assign o_dist = r_dist;

endmodule

// File: rtl/ultrasonic_scheduler.sv
// Round-robin trigger/echo sequencer for N rangefinders sharing one echo timer.
// Optional skip mask for unused sensors via ULTRASONIC_SENSOR_MASK_EN.
module ultrasonic_scheduler
  import ultrasonic_pkg::*;
#(
  parameter int N_SENSORS      = US_N_SENSORS,
  parameter int TRIG_CYCLES    = US_TRIG_CYCLES,
  parameter int TICK_DIV       = US_TICK_DIV,
  parameter int TIMEOUT_CYCLES = US_TIMEOUT_CYCLES,
  parameter int GAP_CYCLES     = US_GAP_CYCLES
) (
  input logic                   i_clk0,
  input logic                   i_rst,
  ultrasonic_scheduler_if.slave io_bus
);

  localparam int IDW   = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;
  localparam int CNT_W = $clog2(us_max3(TRIG_CYCLES, TIMEOUT_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CNT_W-1:0] TRIG_LOAD = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LOAD   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDW-1:0]   LAST_IDX  = IDW'(N_SENSORS - 1);

  us_state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [IDW-1:0]       r_idx, w_idx_nxt;
  logic [N_SENSORS-1:0] r_probe_s1, r_probe_s2, r_probe_s3;
  logic                 w_rise, w_fall;
  logic                 w_publish, w_pub_timeout, w_timer_clr, w_timer_run;
  logic [DIST_W-1:0]    w_dist, r_dist_data;
  logic [IDW-1:0]       r_dist_id;
  logic                 r_dist_valid, r_dist_timeout;

`ifdef ULTRASONIC_SENSOR_MASK_EN
  logic [IDW:0] w_pick;

  // Returns {found, index} of the nearest set mask bit starting at start+first_off.
  function automatic logic [IDW:0] next_in_mask(input logic [N_SENSORS-1:0] mask,
                                                input logic [IDW-1:0] start, input int first_off);
    logic [IDW:0]   res;
    logic [IDW-1:0] p;
    res = {1'b0, start};
    for (int k = N_SENSORS - 1; k >= 0; k--) begin
      p = IDW'((int'(start) + first_off + k) % N_SENSORS);
      if (mask[p]) res = {1'b1, p};
    end
    return res;
  endfunction
`endif

  assign w_rise = r_probe_s2[r_idx] & ~r_probe_s3[r_idx];
  assign w_fall = ~r_probe_s2[r_idx] & r_probe_s3[r_idx];

  ultrasonic_echo_timer #(.TICK_DIV(TICK_DIV)) u_echo_timer (
    .i_clk0  (i_clk0),
    .i_rst   (i_rst),
    .i_clear (w_timer_clr),
    .i_run   (w_timer_run),
    .o_dist  (w_dist)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    w_publish     = 1'b0;
    w_pub_timeout = 1'b0;
    w_timer_clr   = 1'b0;
    w_timer_run   = 1'b0;
`ifdef ULTRASONIC_SENSOR_MASK_EN
    w_pick        = '0;
`endif
    case (r_state)
      ST_IDLE: begin
`ifdef ULTRASONIC_SENSOR_MASK_EN
        w_pick = next_in_mask(io_bus.sensor_mask, r_idx, 0);
        if (io_bus.enable && w_pick[IDW]) begin
          w_idx_nxt   = w_pick[IDW-1:0];
          w_state_nxt = ST_TRIG;
          w_cnt_nxt   = TRIG_LOAD;
        end
`else
        if (io_bus.enable) begin
          w_state_nxt = ST_TRIG;
          w_cnt_nxt   = TRIG_LOAD;
        end
`endif
      end
      ST_TRIG: begin
        w_timer_clr = 1'b1;
        if (r_cnt == '0) begin
          w_state_nxt = ST_WAIT_RISE;
          w_cnt_nxt   = TO_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_WAIT_RISE: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == '0) begin
          w_publish     = 1'b1;
          w_pub_timeout = 1'b1;
          w_state_nxt   = ST_GAP;
          w_cnt_nxt     = GAP_LOAD;
        end else if (w_rise) begin
          // the rise cycle is the first cycle of the echo, so it is counted
          w_timer_run = 1'b1;
          w_state_nxt = ST_MEASURE;
        end else begin
          w_timer_clr = 1'b1;
        end
      end
      ST_MEASURE: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (w_fall) begin
          w_publish   = 1'b1;
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = GAP_LOAD;
        end else if (r_cnt == '0) begin
          w_publish     = 1'b1;
          w_pub_timeout = 1'b1;
          w_state_nxt   = ST_GAP;
          w_cnt_nxt     = GAP_LOAD;
        end else begin
          w_timer_run = 1'b1;
        end
      end
      ST_GAP: begin
        if (r_cnt == '0) begin
`ifdef ULTRASONIC_SENSOR_MASK_EN
          w_pick = next_in_mask(io_bus.sensor_mask, r_idx, 1);
          if (w_pick[IDW]) w_idx_nxt = w_pick[IDW-1:0];
          w_state_nxt = (io_bus.enable && w_pick[IDW]) ? ST_TRIG : ST_IDLE;
`else
          w_idx_nxt   = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
          w_state_nxt = io_bus.enable ? ST_TRIG : ST_IDLE;
`endif
          w_cnt_nxt = (w_state_nxt == ST_TRIG) ? TRIG_LOAD : '0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk0) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_idx          <= '0;
      r_probe_s1     <= '0;
      r_probe_s2     <= '0;
      r_probe_s3     <= '0;
      r_dist_data    <= '0;
      r_dist_id      <= '0;
      r_dist_valid   <= 1'b0;
      r_dist_timeout <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_probe_s1   <= io_bus.probe;
      r_probe_s2   <= r_probe_s1;
      r_probe_s3   <= r_probe_s2;
      r_dist_valid <= w_publish;
      if (w_publish) begin
        r_dist_data    <= w_pub_timeout ? DIST_TIMEOUT_VAL : w_dist;
        r_dist_id      <= r_idx;
        r_dist_timeout <= w_pub_timeout;
      end
    end
  end

  assign io_bus.trig         = (r_state == ST_TRIG) ? (N_SENSORS'(1) << r_idx) : '0;
  assign io_bus.busy         = (r_state != ST_IDLE);
  assign io_bus.dist_data    = r_dist_data;
  assign io_bus.dist_id      = r_dist_id;
  assign io_bus.dist_valid   = r_dist_valid;
  assign io_bus.dist_timeout = r_dist_timeout;

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Scoreboard bench for ultrasonic_scheduler with short timing parameters.
// Mask scenario compiled in with ULTRASONIC_SENSOR_MASK_EN.
module tb_ultrasonic_scheduler;

  localparam int TICK = 3;
  localparam int TOUT = 200;
  localparam int GAP  = 10;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] data;
    logic        to;
  } exp_t;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   last_fall = -1;
  exp_t sb[$];
  exp_t mon_e;

  ultrasonic_scheduler_if #(.N_SENSORS(4)) bus ();

  ultrasonic_scheduler #(
    .N_SENSORS(4), .TRIG_CYCLES(4), .TICK_DIV(TICK), .TIMEOUT_CYCLES(TOUT), .GAP_CYCLES(GAP)
  ) dut (
    .i_clk0 (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Result scoreboard and one-hot trig monitor
  always @(negedge clk) begin
    if (bus.dist_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got id=%0d data=%h to=%b with nothing expected",
                 bus.dist_id, bus.dist_data, bus.dist_timeout);
      end else begin
        mon_e = sb.pop_front();
        if (bus.dist_id !== mon_e.id || bus.dist_data !== mon_e.data || bus.dist_timeout !== mon_e.to) begin
          failures++;
          $display("FAIL sb_result got id=%0d data=%h to=%b want id=%0d data=%h to=%b",
                   bus.dist_id, bus.dist_data, bus.dist_timeout, mon_e.id, mon_e.data, mon_e.to);
        end
      end
    end
    if (bus.trig !== 4'b0000) begin
      checks++;
      if ($countones(bus.trig) != 1) begin
        failures++;
        $display("FAIL trig_onehot got=%b want one bit", bus.trig);
      end
    end
  end

  initial begin
    #400_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "bench stopped by watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.probe = 4'b0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    last_fall = -1;
    sb.delete();
  endtask

  // Serves one trig/echo cycle on sensor id; width=0 means no echo (timeout expected).
  task automatic run_sensor(input int id, input int dly, input int width, input bit drop_en, input bit pre_high);
    bit         seen;
    int         hi;
    int         t_fall;
    int         t_low;
    logic [1:0] sid;
    logic [3:0] exp_trig;
    exp_t       e;
    sid = 2'(id);
    exp_trig = 4'(1 << id);
    seen = 1'b0;
    for (int k = 0; k < 1000 && !seen; k++) begin
      @(negedge clk);
      seen = (bus.trig !== 4'b0000);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL trig_start id=%0d got no trig within 1000 cycles", id);
      return;
    end
    checks++;
    if (bus.trig !== exp_trig) begin
      failures++;
      $display("FAIL trig_sel got=%b want=%b", bus.trig, exp_trig);
    end
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_run got=%b want=1", bus.busy);
    end
    if (last_fall >= 0) begin
      checks++;
      if (cyc - last_fall < GAP) begin
        failures++;
        $display("FAIL trig_gap got idle=%0d want>=%0d", cyc - last_fall, GAP);
      end
    end
    if (pre_high) bus.probe[sid] = 1'b1;
    hi = 1;
    for (int k = 0; k < 20 && bus.trig !== 4'b0000; k++) begin
      @(negedge clk);
      if (bus.trig !== 4'b0000) hi++;
    end
    checks++;
    if (hi != 4) begin
      failures++;
      $display("FAIL trig_width id=%0d got=%0d want=4", id, hi);
    end
    t_fall = cyc;
    last_fall = cyc;
    seen = 1'b0;
    if (width > 0 && !pre_high) begin
      repeat (dly) @(negedge clk);
      e.id = sid; e.data = 16'(width / TICK); e.to = 1'b0;
      sb.push_back(e);
      bus.probe[sid] = 1'b1;
      for (int k = 0; k < width; k++) begin
        @(negedge clk);
        if (drop_en && k == width / 2) bus.enable = 1'b0;
      end
      bus.probe[sid] = 1'b0;
      t_low = cyc;
      for (int k = 0; k < 400 && !seen; k++) begin
        @(negedge clk);
        seen = (bus.dist_valid === 1'b1);
      end
      checks++;
      if (!seen) begin
        failures++;
        $display("FAIL echo_valid id=%0d got no dist_valid within 400 cycles", id);
      end else if (cyc - t_low != 3) begin
        failures++;
        $display("FAIL echo_latency id=%0d got=%0d want=3", id, cyc - t_low);
      end
    end else begin
      e.id = sid; e.data = 16'hFFFF; e.to = 1'b1;
      sb.push_back(e);
      if (pre_high) begin
        repeat (dly) @(negedge clk);
        bus.probe[sid] = 1'b0;
      end
      for (int k = 0; k < 400 && !seen; k++) begin
        @(negedge clk);
        seen = (bus.dist_valid === 1'b1);
      end
      checks++;
      if (!seen) begin
        failures++;
        $display("FAIL timeout_valid id=%0d got no dist_valid within 400 cycles", id);
      end else if (cyc - t_fall != TOUT) begin
        failures++;
        $display("FAIL timeout_latency id=%0d got=%0d want=%0d", id, cyc - t_fall, TOUT);
      end
    end
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_pending got=%0d want=0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.probe = 4'b0000;
`ifdef ULTRASONIC_SENSOR_MASK_EN
    bus.sensor_mask = 4'b1111;
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (bus.trig !== 4'b0000 || bus.dist_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl got trig=%b valid=%b busy=%b want 0000/0/0", bus.trig, bus.dist_valid, bus.busy);
    end
    checks++;
    if (bus.dist_data !== 16'h0000 || bus.dist_id !== 2'd0 || bus.dist_timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_data got data=%h id=%0d to=%b want 0000/0/0", bus.dist_data, bus.dist_id, bus.dist_timeout);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_echo();
    bus.enable = 1'b1;
    run_sensor(0, 5, 30, 1'b0, 1'b0);
  endtask

  task automatic test_no_echo();
    run_sensor(1, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_probe_high();
    run_sensor(2, 20, 0, 1'b0, 1'b1);
  endtask

  task automatic test_continuous();
    do_reset();
    bus.enable = 1'b1;
    run_sensor(0, 2, 9, 1'b0, 1'b0);
    run_sensor(1, 7, 13, 1'b0, 1'b0);
    run_sensor(2, 1, 1, 1'b0, 1'b0);
    run_sensor(3, 4, 30, 1'b0, 1'b0);
    run_sensor(0, 3, 4, 1'b0, 1'b0);
  endtask

  task automatic test_enable_drop();
    int n_trig;
    run_sensor(1, 3, 12, 1'b0, 1'b0);
    run_sensor(2, 2, 18, 1'b1, 1'b0);
    repeat (GAP + 2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.trig !== 4'b0000) begin
      failures++;
      $display("FAIL drop_idle got busy=%b trig=%b want 0/0000", bus.busy, bus.trig);
    end
    n_trig = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.trig !== 4'b0000) n_trig++;
    end
    checks++;
    if (n_trig != 0) begin
      failures++;
      $display("FAIL drop_quiet got trig_cycles=%0d want=0", n_trig);
    end
    bus.enable = 1'b1;
    run_sensor(3, 4, 6, 1'b0, 1'b0);
  endtask

  task automatic test_rst_mid();
    bit seen;
    int n_valid;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      seen = (bus.trig === 4'b0001);
    end
    for (int k = 0; k < 20 && bus.trig !== 4'b0000; k++) @(negedge clk);
    checks++;
    if (!seen || bus.trig !== 4'b0000) begin
      failures++;
      $display("FAIL rst_setup got seen=%b trig=%b want 1/0000", seen, bus.trig);
    end
    repeat (3) @(negedge clk);
    bus.probe[0] = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.trig !== 4'b0000 || bus.dist_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_ctrl got trig=%b valid=%b busy=%b want 0000/0/0", bus.trig, bus.dist_valid, bus.busy);
    end
    checks++;
    if (bus.dist_data !== 16'h0000 || bus.dist_id !== 2'd0 || bus.dist_timeout !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_data got data=%h id=%0d to=%b want 0000/0/0", bus.dist_data, bus.dist_id, bus.dist_timeout);
    end
    bus.probe = 4'b0000;
    bus.enable = 1'b0;
    rst = 1'b0;
    n_valid = 0;
    repeat (250) begin
      @(negedge clk);
      if (bus.dist_valid !== 1'b0 || bus.trig !== 4'b0000) n_valid++;
    end
    checks++;
    if (n_valid != 0) begin
      failures++;
      $display("FAIL rst_quiet got active_cycles=%0d want=0", n_valid);
    end
  endtask

`ifdef ULTRASONIC_SENSOR_MASK_EN
  task automatic test_mask();
    int n_trig;
    do_reset();
    bus.sensor_mask = 4'b1010;
    bus.enable = 1'b1;
    run_sensor(1, 2, 9, 1'b0, 1'b0);
    run_sensor(3, 3, 6, 1'b0, 1'b0);
    run_sensor(1, 1, 15, 1'b0, 1'b0);
    run_sensor(3, 5, 3, 1'b0, 1'b0);
    bus.sensor_mask = 4'b0000;
    n_trig = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.trig !== 4'b0000) n_trig++;
    end
    checks++;
    if (n_trig != 0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL mask_zero got trig_cycles=%0d busy=%b want 0/0", n_trig, bus.busy);
    end
    bus.enable = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_echo();
    test_no_echo();
    test_probe_high();
    test_continuous();
    test_enable_drop();
    test_rst_mid();
`ifdef ULTRASONIC_SENSOR_MASK_EN
    test_mask();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
